// File: rtl/spi_sample_sched_if.sv
// SPI master request/transfer handshake and sample
// consumer valid/ack handshake for spi_sample_sched.
interface spi_sample_sched_if #(
  parameter int DATA_W = 16
);
  logic              spi_req;
  logic              spi_busy;
  logic              spi_done;
  logic [DATA_W-1:0] spi_rdata;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ack;

  modport master (
    output spi_req,
    output sample,
    output sample_valid,
    input  spi_busy,
    input  spi_done,
    input  spi_rdata,
    input  sample_ack
  );

  modport slave (
    input  spi_req,
    input  sample,
    input  sample_valid,
    output spi_busy,
    output spi_done,
    output spi_rdata,
    output sample_ack
  );
endinterface

// File: rtl/spi_sample_sched.sv
// Periodic temperature sample scheduler: period ticks,
// SPI read sequencing with timeout/retry, sample holding.
module spi_sample_sched #(
  parameter int CNT_W     = 24,
  parameter int PERIOD    = 1000000,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 2,
  parameter int DATA_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               start_now,
  spi_sample_sched_if.master bus,
  output logic               tick,
  output logic               overrun,
  output logic               timeout_err,
  input  logic               clr_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] PLAST = CNT_W'(PERIOD - 1);
  localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]       RMAX  = 3'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    BACKOFF
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  pcnt;
  logic [TW-1:0]     tcnt;
  logic [TW-1:0]     tcnt_n;
  logic [2:0]        retry;
  logic [2:0]        retry_n;
  logic              trig;
  logic              latch;
  logic              to_set;
  logic              ovr_set;
  logic [DATA_W-1:0] smp;
  logic              vld;

  assign tick    = enable && (pcnt == PLAST);
  assign trig    = enable && (tick || start_now);
  assign ovr_set = latch && vld && !bus.sample_ack;

  assign bus.spi_req      = (state == REQ);
  assign bus.sample       = smp;
  assign bus.sample_valid = vld;

  // period counter, held at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!enable || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // sequencer state, attempt timer and retry count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tcnt  <= '0;
      retry <= '0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      retry <= retry_n;
    end
  end

  // next state; a done pulse beats an expiring timer
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    retry_n = retry;
    latch   = 1'b0;
    to_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig) begin
          state_n = REQ;
          tcnt_n  = '0;
          retry_n = '0;
        end
      end
      REQ, XFER: begin
        if (bus.spi_done) begin
          latch   = 1'b1;
          state_n = IDLE;
        end else if (tcnt == TLAST) begin
          if (retry < RMAX) begin
            state_n = BACKOFF;
            retry_n = retry + 3'd1;
          end else begin
            to_set  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          tcnt_n = tcnt + 1'b1;
          if (state == REQ && bus.spi_busy) begin
            state_n = XFER;
          end
        end
      end
      BACKOFF: begin
        tcnt_n  = '0;
        state_n = REQ;
      end
    endcase
  end

  // sample register with valid/ack handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp <= '0;
      vld <= 1'b0;
    end else if (latch) begin
      smp <= bus.spi_rdata;
      vld <= 1'b1;
    end else if (bus.sample_ack) begin
      vld <= 1'b0;
    end
  end

  // sticky error flags, set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (to_set) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_sample_sched.sv
// Bench for spi_sample_sched: directed steps plus random
// reads against a transaction-level sample/flag model.
module tb_spi_sample_sched;

  localparam int PERIOD    = 10;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 2;
  localparam int DW        = 16;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic enable    = 1'b0;
  logic start_now = 1'b0;
  logic clr_err   = 1'b0;
  logic tick;
  logic overrun;
  logic timeout_err;

  spi_sample_sched_if #(.DATA_W(DW)) bus();

  spi_sample_sched #(
    .CNT_W    (8),
    .PERIOD   (PERIOD),
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY),
    .DATA_W   (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .start_now  (start_now),
    .bus        (bus),
    .tick       (tick),
    .overrun    (overrun),
    .timeout_err(timeout_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_sample;
  logic          m_valid;
  logic          m_over;

  bit            sl_on;
  bit            sl_act;
  bit            sl_ackd;
  int            sl_bd;
  int            sl_dd;
  int            sl_cnt;
  logic [DW-1:0] sl_data;

  int   n_rise;
  int   n_reqhi;
  int   n_ticks;
  logic prev_req;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic          d;
    logic          a;
    logic          c;
    logic [DW-1:0] r;
    d = bus.spi_done;
    a = bus.sample_ack;
    c = clr_err;
    r = bus.spi_rdata;
    @(posedge clk);
    #1;
    start_now      = 1'b0;
    clr_err        = 1'b0;
    bus.sample_ack = 1'b0;
    bus.spi_done   = 1'b0;
    if (rst_n) begin
      if (d && m_valid && !a) m_over = 1'b1;
      else if (c) m_over = 1'b0;
      if (d) begin
        m_sample = r;
        m_valid  = 1'b1;
      end else if (a) begin
        m_valid = 1'b0;
      end
    end
    if (bus.spi_req && !prev_req) n_rise++;
    if (bus.spi_req) n_reqhi++;
    if (tick) n_ticks++;
    prev_req = bus.spi_req;
    if (sl_on && rst_n) begin
      if (!sl_act && bus.spi_req) begin
        sl_act = 1'b1;
        sl_cnt = 0;
      end
      if (sl_act) begin
        sl_cnt++;
        if (sl_cnt == sl_bd) bus.spi_busy = 1'b1;
        if (sl_cnt == sl_bd + sl_dd) begin
          bus.spi_busy   = 1'b0;
          bus.spi_done   = 1'b1;
          bus.spi_rdata  = sl_data;
          bus.sample_ack = sl_ackd;
          sl_act         = 1'b0;
        end
      end
    end
    chk("sample", 32'(bus.sample), 32'(m_sample));
    chk("valid", 32'(bus.sample_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_over));
  endtask

  task automatic read(input logic [DW-1:0] data,
                      input int bd,
                      input int dd,
                      input bit ackd,
                      input int ncyc);
    sl_on   = 1'b1;
    sl_act  = 1'b0;
    sl_bd   = bd;
    sl_dd   = dd;
    sl_data = data;
    sl_ackd = ackd;
    n_rise  = 0;
    n_reqhi = 0;
    enable    = 1'b1;
    start_now = 1'b1;
    cyc();
    enable = 1'b0;
    repeat (ncyc) cyc();
    chk("one_txn", 32'(n_rise), 32'd1);
  endtask

  initial begin
    int w;
    int tot;
    int bd;
    int dd;
    bus.spi_busy   = 1'b0;
    bus.spi_done   = 1'b0;
    bus.spi_rdata  = '0;
    bus.sample_ack = 1'b0;
    m_sample = '0;
    m_valid  = 1'b0;
    m_over   = 1'b0;
    prev_req = 1'b0;
    sl_act   = 1'b0;

    // reset state, then ticks with reads served
    enable  = 1'b1;
    sl_on   = 1'b1;
    sl_bd   = 2;
    sl_dd   = 5;
    sl_data = 16'h1234;
    sl_ackd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.spi_req), 32'd0);
    chk("rst_sample", 32'(bus.sample), 32'd0);
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      chk("tick", 32'(tick),
          32'((k % PERIOD) == PERIOD - 1));
    end
    chk("req_after_tick", 32'(bus.spi_req), 32'd1);
    repeat (3) cyc();
    chk("pre_rst_valid", 32'(bus.sample_valid), 32'd1);
    chk("pre_rst_ovr", 32'(overrun), 32'd1);

    // asynchronous reset in the middle of a transfer
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus.spi_req), 32'd0);
    chk("arst_sample", 32'(bus.sample), 32'd0);
    chk("arst_valid", 32'(bus.sample_valid), 32'd0);
    chk("arst_ovr", 32'(overrun), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    sl_on        = 1'b0;
    sl_act       = 1'b0;
    bus.spi_busy = 1'b0;
    bus.spi_done = 1'b0;
    enable       = 1'b0;
    m_sample     = '0;
    m_valid      = 1'b0;
    m_over       = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // normal read then ack
    read(16'h0A5C, 2, 5, 1'b0, 10);
    chk("req_cycles", 32'(n_reqhi), 32'd2);
    chk("rd_sample", 32'(bus.sample), 32'h0A5C);
    chk("rd_valid", 32'(bus.sample_valid), 32'd1);
    bus.sample_ack = 1'b1;
    cyc();
    chk("ack_valid", 32'(bus.sample_valid), 32'd0);

    // overrun, ack on latch, clear
    read(16'h0100, 2, 5, 1'b0, 10);
    read(16'h0200, 2, 5, 1'b0, 10);
    chk("ovr_sample", 32'(bus.sample), 32'h0200);
    chk("ovr_set", 32'(overrun), 32'd1);
    clr_err = 1'b1;
    cyc();
    chk("ovr_clr", 32'(overrun), 32'd0);
    read(16'h0300, 2, 5, 1'b1, 10);
    read(16'h0400, 1, 3, 1'b1, 10);
    chk("ackl_sample", 32'(bus.sample), 32'h0400);
    chk("ackl_valid", 32'(bus.sample_valid), 32'd1);
    chk("ackl_ovr", 32'(overrun), 32'd0);

    // every attempt times out
    w   = TIMEOUT + 1;
    tot = (MAX_RETRY + 1) * w;
    sl_on  = 1'b0;
    sl_act = 1'b0;
    n_rise = 0;
    enable    = 1'b1;
    start_now = 1'b1;
    cyc();
    enable = 1'b0;
    for (int j = 1; j <= tot; j++) begin
      if (j > 1) cyc();
      chk("req_win", 32'(bus.spi_req),
          32'((j < tot) && (j % w != 0)));
      if (j == tot - 1) begin
        chk("terr_early", 32'(timeout_err), 32'd0);
      end
    end
    chk("terr_set", 32'(timeout_err), 32'd1);
    chk("terr_attempts", 32'(n_rise), 32'(MAX_RETRY + 1));
    chk("terr_sample", 32'(bus.sample), 32'h0400);
    repeat (3) cyc();
    chk("terr_idle", 32'(bus.spi_req), 32'd0);
    clr_err = 1'b1;
    cyc();
    chk("terr_clr", 32'(timeout_err), 32'd0);

    // first attempt times out, second succeeds
    n_rise    = 0;
    enable    = 1'b1;
    start_now = 1'b1;
    cyc();
    enable = 1'b0;
    repeat (TIMEOUT) cyc();
    sl_on   = 1'b1;
    sl_act  = 1'b0;
    sl_bd   = 2;
    sl_dd   = 3;
    sl_data = 16'hBEEF;
    sl_ackd = 1'b0;
    repeat (8) cyc();
    chk("retry_sample", 32'(bus.sample), 32'hBEEF);
    chk("retry_terr", 32'(timeout_err), 32'd0);
    chk("retry_rises", 32'(n_rise), 32'd2);

    // start_now during transfer, then enable drop
    sl_on   = 1'b1;
    sl_act  = 1'b0;
    sl_bd   = 2;
    sl_dd   = 5;
    sl_data = 16'h5A5A;
    n_rise  = 0;
    enable    = 1'b1;
    start_now = 1'b1;
    repeat (4) cyc();
    start_now = 1'b1;
    cyc();
    enable  = 1'b0;
    n_ticks = 0;
    repeat (25) cyc();
    chk("coll_rises", 32'(n_rise), 32'd1);
    chk("coll_sample", 32'(bus.sample), 32'h5A5A);
    chk("no_ticks", 32'(n_ticks), 32'd0);

    // start_now ignored while disabled
    n_rise    = 0;
    start_now = 1'b1;
    repeat (5) cyc();
    chk("dis_rises", 32'(n_rise), 32'd0);

    // done coincides with the last timeout cycle
    read(16'h7E57, 3, TIMEOUT - 3, 1'b0, 20);
    chk("tie_sample", 32'(bus.sample), 32'h7E57);
    chk("tie_terr", 32'(timeout_err), 32'd0);

    // random reads against the model
    for (int i = 0; i < 40; i++) begin
      bd = $urandom_range(1, 3);
      dd = $urandom_range(1, TIMEOUT - bd);
      sl_on   = 1'b1;
      sl_act  = 1'b0;
      sl_bd   = bd;
      sl_dd   = dd;
      sl_data = DW'($urandom);
      sl_ackd = 1'($urandom_range(0, 1));
      n_rise  = 0;
      enable    = 1'b1;
      start_now = 1'b1;
      cyc();
      if ($urandom_range(0, 1) == 1) begin
        start_now = 1'b1;
      end else begin
        enable = 1'b0;
      end
      for (int j = 0; j < 12; j++) begin
        if ($urandom_range(0, 3) == 0) bus.sample_ack = 1'b1;
        if ($urandom_range(0, 7) == 0) clr_err = 1'b1;
        cyc();
        enable = 1'b0;
      end
      chk("rnd_one_txn", 32'(n_rise), 32'd1);
    end
    chk("rnd_terr", 32'(timeout_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
